// File: rtl/avalon_uart_remote_bridge.sv
`timescale 1ns/1ps
// avalon_uart_remote_bridge
//   Avalon-MM responder that tunnels each read/write over an 8N1 UART link
//   to a remote avalon_uart_host. Writes are posted (10-byte packet, no
//   response). Reads send a 5-byte packet and then collect 4 response bytes.
//   If the response bytes do not arrive in time, the read completes with
//   TIMEOUT_DATA and the sticky timeout_err flag is set.
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   avn_read / avn_write     request strobes, held until waitrequest is low
//   avn_address              remote byte address, forwarded unchanged
//   avn_byte_enable          write byte enables
//   avn_writedata            write data
//   avn_readdata             read data, valid in the read completion cycle
//   avn_waitrequest          stall; low only in the completion cycle or when idle
//   uart_div                 clocks per UART bit (>=4), sampled per byte
//   uart_txd / uart_rxd      serial out (idle high) / asynchronous serial in
//   timeout_err              sticky read-timeout flag, cleared by reset only
module avalon_uart_remote_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        avn_read,
  input  logic        avn_write,
  input  logic [31:0] avn_address,
  input  logic [3:0]  avn_byte_enable,
  input  logic [31:0] avn_writedata,
  output logic [31:0] avn_readdata,
  output logic        avn_waitrequest,
  input  logic [15:0] uart_div,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_CMD  = 3'd1,
    ST_TX_ADDR = 3'd2,
    ST_TX_BE   = 3'd3,
    ST_TX_DATA = 3'd4,
    ST_RX_DATA = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  // Byte k of a 32-bit word, LSB first on the wire.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Request latch and FSM
  state_t      state_r;
  logic        is_write_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [1:0]  byte_cnt_r;
  logic [31:0] to_cnt_r;
  logic [31:0] rx_word_r;

  // TX shifter: tx_data_r holds {stop, d7..d0}; uart_txd carries the current bit.
  logic        tx_busy_r;
  logic [8:0]  tx_data_r;
  logic [3:0]  tx_bit_r;
  logic [15:0] tx_clk_r;
  logic [15:0] tx_div_r;
  logic        tx_byte_end_s;
  logic        tx_load_s;
  logic [7:0]  tx_load_byte_s;

  // RX synchronizer and deserializer
  logic        rxd_meta_r;
  logic        rxd_sync_r;
  logic        rxd_prev_r;
  logic        rx_busy_r;
  logic [15:0] rx_clk_r;
  logic [15:0] rx_div_r;
  logic [3:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic        rx_valid_r;

  logic        done_s;

  assign done_s          = (state_r == ST_DONE);
  assign avn_waitrequest = (avn_read | avn_write) & ~done_s;
  // Last clock of the stop bit: the next byte loads on this edge, so no idle gap.
  assign tx_byte_end_s   = tx_busy_r & (tx_clk_r == 16'd0) & (tx_bit_r == 4'd9);

  // Select which byte (if any) enters the TX shifter on this edge.
  always_comb begin
    tx_load_s      = 1'b0;
    tx_load_byte_s = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (avn_read | avn_write) begin
          tx_load_s      = 1'b1;
          tx_load_byte_s = avn_write ? 8'h57 : 8'h52;
        end else begin
          tx_load_s      = 1'b0;
        end
      end
      ST_TX_CMD: begin
        tx_load_s      = tx_byte_end_s;
        tx_load_byte_s = addr_r[7:0];
      end
      ST_TX_ADDR: begin
        if (byte_cnt_r != 2'd3) begin
          tx_load_s      = tx_byte_end_s;
          tx_load_byte_s = byte_of(addr_r, byte_cnt_r + 2'd1);
        end else if (is_write_r) begin
          tx_load_s      = tx_byte_end_s;
          tx_load_byte_s = {4'h0, be_r};
        end else begin
          tx_load_s      = 1'b0;
        end
      end
      ST_TX_BE: begin
        tx_load_s      = tx_byte_end_s;
        tx_load_byte_s = wdata_r[7:0];
      end
      ST_TX_DATA: begin
        if (byte_cnt_r != 2'd3) begin
          tx_load_s      = tx_byte_end_s;
          tx_load_byte_s = byte_of(wdata_r, byte_cnt_r + 2'd1);
        end else begin
          tx_load_s      = 1'b0;
        end
      end
      default: begin
        tx_load_s      = 1'b0;
        tx_load_byte_s = 8'h00;
      end
    endcase
  end

  // TX bit engine: start, 8 data bits, stop, each uart_div clocks long.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_txd  <= 1'b1;
      tx_busy_r <= 1'b0;
      tx_data_r <= 9'h1FF;
      tx_bit_r  <= 4'd0;
      tx_clk_r  <= 16'd0;
      tx_div_r  <= 16'd0;
    end else if (tx_load_s) begin
      uart_txd  <= 1'b0;
      tx_busy_r <= 1'b1;
      tx_data_r <= {1'b1, tx_load_byte_s};
      tx_bit_r  <= 4'd0;
      tx_clk_r  <= uart_div - 16'd1;
      tx_div_r  <= uart_div;
    end else if (tx_busy_r) begin
      if (tx_clk_r != 16'd0) begin
        tx_clk_r <= tx_clk_r - 16'd1;
      end else if (tx_bit_r == 4'd9) begin
        tx_busy_r <= 1'b0;
        uart_txd  <= 1'b1;
      end else begin
        uart_txd  <= tx_data_r[0];
        tx_data_r <= {1'b1, tx_data_r[8:1]};
        tx_bit_r  <= tx_bit_r + 4'd1;
        tx_clk_r  <= tx_div_r - 16'd1;
      end
    end
  end

  // RX: synchronize, detect start edge, sample bit centres, validate stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
      rx_busy_r  <= 1'b0;
      rx_clk_r   <= 16'd0;
      rx_div_r   <= 16'd0;
      rx_bit_r   <= 4'd0;
      rx_shift_r <= 8'h00;
      rx_valid_r <= 1'b0;
    end else begin
      rxd_meta_r <= uart_rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
      rx_valid_r <= 1'b0;
      if (!rx_busy_r) begin
        if (rxd_prev_r & ~rxd_sync_r) begin
          // Wait half a bit so the start bit is re-checked near its centre.
          rx_busy_r <= 1'b1;
          rx_clk_r  <= {1'b0, uart_div[15:1]} - 16'd1;
          rx_div_r  <= uart_div;
          rx_bit_r  <= 4'd0;
        end
      end else if (rx_clk_r != 16'd0) begin
        rx_clk_r <= rx_clk_r - 16'd1;
      end else if (rx_bit_r == 4'd0) begin
        if (rxd_sync_r) begin
          rx_busy_r <= 1'b0;              // glitch, not a real start bit
        end else begin
          rx_bit_r  <= 4'd1;
          rx_clk_r  <= rx_div_r - 16'd1;
        end
      end else if (rx_bit_r != 4'd9) begin
        rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
        rx_bit_r   <= rx_bit_r + 4'd1;
        rx_clk_r   <= rx_div_r - 16'd1;
      end else begin
        // Stop bit: a low level is a framing error and the byte is dropped.
        rx_busy_r  <= 1'b0;
        rx_valid_r <= rxd_sync_r;
      end
    end
  end

  // Transaction FSM: latch request, sequence packet bytes, gather response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      is_write_r   <= 1'b0;
      addr_r       <= 32'h0;
      be_r         <= 4'h0;
      wdata_r      <= 32'h0;
      byte_cnt_r   <= 2'd0;
      to_cnt_r     <= 32'd0;
      rx_word_r    <= 32'h0;
      avn_readdata <= 32'h0;
      timeout_err  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (avn_read | avn_write) begin
            is_write_r <= avn_write;
            addr_r     <= avn_address;
            be_r       <= avn_byte_enable;
            wdata_r    <= avn_writedata;
            byte_cnt_r <= 2'd0;
            state_r    <= ST_TX_CMD;
          end
        end
        ST_TX_CMD: begin
          if (tx_byte_end_s) begin
            byte_cnt_r <= 2'd0;
            state_r    <= ST_TX_ADDR;
          end
        end
        ST_TX_ADDR: begin
          if (tx_byte_end_s) begin
            if (byte_cnt_r != 2'd3) begin
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end else if (is_write_r) begin
              state_r    <= ST_TX_BE;
            end else begin
              byte_cnt_r <= 2'd0;
              to_cnt_r   <= 32'd0;
              state_r    <= ST_RX_DATA;
            end
          end
        end
        ST_TX_BE: begin
          if (tx_byte_end_s) begin
            byte_cnt_r <= 2'd0;
            state_r    <= ST_TX_DATA;
          end
        end
        ST_TX_DATA: begin
          if (tx_byte_end_s) begin
            if (byte_cnt_r != 2'd3) begin
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end else begin
              state_r    <= ST_DONE;
            end
          end
        end
        ST_RX_DATA: begin
          if (rx_valid_r) begin
            rx_word_r[{byte_cnt_r, 3'b000} +: 8] <= rx_shift_r;
            if (byte_cnt_r == 2'd3) begin
              avn_readdata <= {rx_shift_r, rx_word_r[23:0]};
              state_r      <= ST_DONE;
            end else begin
              byte_cnt_r   <= byte_cnt_r + 2'd1;
            end
          end else if (to_cnt_r == TIMEOUT_LAST) begin
            avn_readdata <= TIMEOUT_DATA;
            timeout_err  <= 1'b1;
            state_r      <= ST_DONE;
          end else begin
            to_cnt_r     <= to_cnt_r + 32'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_uart_remote_bridge.sv
`timescale 1ns/1ps
module tb_avalon_uart_remote_bridge;

  localparam int DIV = 4;
  localparam int TO  = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        avn_read;
  logic        avn_write;
  logic [31:0] avn_address;
  logic [3:0]  avn_byte_enable;
  logic [31:0] avn_writedata;
  logic [31:0] avn_readdata;
  logic        avn_waitrequest;
  logic [15:0] uart_div;
  logic        uart_txd;
  logic        uart_rxd;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int rst_epoch = 0;
  logic [7:0]  exp_tx_q[$];
  logic [31:0] exp_rd_q[$];

  avalon_uart_remote_bridge #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .avn_read(avn_read), .avn_write(avn_write), .avn_address(avn_address),
    .avn_byte_enable(avn_byte_enable), .avn_writedata(avn_writedata),
    .avn_readdata(avn_readdata), .avn_waitrequest(avn_waitrequest),
    .uart_div(uart_div), .uart_txd(uart_txd), .uart_rxd(uart_rxd),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Decode uart_txd bytes and compare each against the expected-byte scoreboard.
  initial begin : tx_monitor
    forever begin
      int         ep;
      logic [7:0] b;
      logic       stopb;
      logic [7:0] e;
      @(negedge uart_txd);
      ep = rst_epoch;
      repeat (DIV / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(posedge clk);
        b[i] = uart_txd;
      end
      repeat (DIV) @(posedge clk);
      stopb = uart_txd;
      if (ep == rst_epoch) begin
        checks++;
        if (exp_tx_q.size() == 0) begin
          errors++;
          $display("FAIL tx_extra: got byte %02h stop=%b, expected no byte", b, stopb);
        end else begin
          e = exp_tx_q.pop_front();
          if ({stopb, b} !== {1'b1, e}) begin
            errors++;
            $display("FAIL tx_byte: got %02h stop=%b, expected %02h stop=1", b, stopb, e);
          end
        end
      end
    end
  end

  task automatic start_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] data);
    avn_read = rd; avn_write = wr; avn_address = addr;
    avn_byte_enable = be; avn_writedata = data;
    exp_tx_q.push_back(wr ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) exp_tx_q.push_back(addr[8*i +: 8]);
    if (wr) begin
      exp_tx_q.push_back({4'h0, be});
      for (int i = 0; i < 4; i++) exp_tx_q.push_back(data[8*i +: 8]);
    end
  endtask

  task automatic wait_done(input int budget, output int cycles, output logic ok,
                           output logic [31:0] rd, output logic terr);
    cycles = 0; ok = 1'b0; rd = 32'h0; terr = 1'b0;
    while (!ok && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (avn_waitrequest === 1'b0) begin
        ok = 1'b1; rd = avn_readdata; terr = timeout_err;
      end
    end
    avn_read = 1'b0; avn_write = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  // Remote host: waits, then returns word LSB first; optionally a bad-stop byte before byte 2.
  task automatic remote_reply(input int delay, input logic [31:0] word, input logic bad);
    repeat (delay) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (bad && k == 2) send_byte(8'h5A, 1'b0);
      send_byte(word[8*k +: 8], 1'b1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; avn_read = 1'b0; avn_write = 1'b0; avn_address = 32'h0;
    avn_byte_enable = 4'h0; avn_writedata = 32'h0; uart_div = 16'(DIV); uart_rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
    checks++; if (avn_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", avn_readdata); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
    checks++; if (avn_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b expected 0", avn_waitrequest); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write;
    int cyc; logic ok; logic [31:0] rd; logic terr;
    @(negedge clk);
    start_req(1'b0, 1'b1, 32'h1000_0004, 4'h3, 32'hA5A5_1234);
    wait_done(2000, cyc, ok, rd, terr);
    checks++; if (!ok) begin errors++; $display("FAIL write_done: got no completion, expected one"); end
    checks++; if (cyc != 1 + 100 * DIV) begin errors++; $display("FAIL write_latency: got %0d expected %0d", cyc, 1 + 100 * DIV); end
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL write_txd_idle: got %b expected 1", uart_txd); end
    checks++; if (exp_tx_q.size() != 0) begin errors++; $display("FAIL write_tx_missing: got %0d left expected 0", exp_tx_q.size()); exp_tx_q.delete(); end
    repeat (5) @(negedge clk);
  endtask

  task automatic do_read(input string name, input logic [31:0] addr, input logic [31:0] word,
                         input logic bad, input logic exp_terr);
    int cyc; logic ok; logic [31:0] rd; logic terr; logic [31:0] e;
    @(negedge clk);
    start_req(1'b1, 1'b0, addr, 4'h0, 32'h0);
    exp_rd_q.push_back(word);
    fork
      remote_reply(50 * DIV + 50, word, bad);
      wait_done(3000, cyc, ok, rd, terr);
    join
    e = exp_rd_q.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL %s_done: got no completion, expected one", name); end
    checks++; if (rd !== e) begin errors++; $display("FAIL %s_rdata: got %h expected %h", name, rd, e); end
    checks++; if (terr !== exp_terr) begin errors++; $display("FAIL %s_terr: got %b expected %b", name, terr, exp_terr); end
    checks++; if (avn_readdata !== e) begin errors++; $display("FAIL %s_hold: got %h expected %h", name, avn_readdata, e); end
    checks++; if (exp_tx_q.size() != 0) begin errors++; $display("FAIL %s_tx_missing: got %0d left expected 0", name, exp_tx_q.size()); exp_tx_q.delete(); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc; logic ok; logic [31:0] rd; logic terr;
    @(negedge clk);
    start_req(1'b1, 1'b1, 32'h3000_0008, 4'hF, 32'h0BAD_F00D);
    wait_done(2000, cyc, ok, rd, terr);
    checks++; if (!ok || cyc != 1 + 100 * DIV) begin errors++; $display("FAIL both_latency: got %0d ok=%b expected %0d", cyc, ok, 1 + 100 * DIV); end
    start_req(1'b0, 1'b1, 32'h4000_0001, 4'h1, 32'hCAFE_BABE);
    wait_done(2000, cyc, ok, rd, terr);
    checks++; if (!ok || cyc != 2 + 100 * DIV) begin errors++; $display("FAIL b2b_latency: got %0d ok=%b expected %0d", cyc, ok, 2 + 100 * DIV); end
    checks++; if (exp_tx_q.size() != 0) begin errors++; $display("FAIL b2b_tx_missing: got %0d left expected 0", exp_tx_q.size()); exp_tx_q.delete(); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    avn_read = 1'b1; avn_write = 1'b0; avn_address = 32'h5040_3020;
    exp_tx_q.push_back(8'h52); exp_tx_q.push_back(8'h20); exp_tx_q.push_back(8'h30);
    repeat (30 * DIV + 3 * DIV) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; rst_epoch++; avn_read = 1'b0;
    @(posedge clk); #1;
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd: got %b expected 1", uart_txd); end
    checks++; if (avn_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_mid_wait: got %b expected 0", avn_waitrequest); end
    @(negedge clk); rst = 1'b0;
    repeat (15 * DIV) @(negedge clk);
    checks++; if (exp_tx_q.size() != 0) begin errors++; $display("FAIL rst_mid_tx_missing: got %0d left expected 0", exp_tx_q.size()); exp_tx_q.delete(); end
    do_read("rst_fresh", 32'h6000_0000, 32'h4433_2211, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    int cyc; logic ok; logic [31:0] rd; logic terr; logic [31:0] e;
    @(negedge clk);
    start_req(1'b1, 1'b0, 32'h7000_0000, 4'h0, 32'h0);
    exp_rd_q.push_back(32'hDEAD_BEEF);
    wait_done(5000, cyc, ok, rd, terr);
    e = exp_rd_q.pop_front();
    checks++; if (!ok || cyc != 1 + 50 * DIV + TO) begin errors++; $display("FAIL to_latency: got %0d ok=%b expected %0d", cyc, ok, 1 + 50 * DIV + TO); end
    checks++; if (rd !== e) begin errors++; $display("FAIL to_rdata: got %h expected %h", rd, e); end
    checks++; if (terr !== 1'b1) begin errors++; $display("FAIL to_terr: got %b expected 1", terr); end
    repeat (20) @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    checks++; if (exp_tx_q.size() != 0) begin errors++; $display("FAIL to_tx_missing: got %0d left expected 0", exp_tx_q.size()); exp_tx_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_write();
    do_read("read", 32'h2000_0000, 32'h1234_5678, 1'b0, 1'b0);
    do_read("bad_stop", 32'h2000_0010, 32'h90A1_B2C3, 1'b1, 1'b0);
    test_back_to_back();
    test_rst_mid();
    test_timeout();
    do_read("sticky", 32'h8000_0000, 32'h0102_0304, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
